// File: rtl/tcdm_banks_pipe_wrap.sv
// ---------------------------------------------------------------------------
// tcdm_banks_pipe_wrap
//
// A set of NB_BANKS independent single-port memory banks with a configurable
// read pipeline and a built-in init sequencer. After reset, or on request, the
// sequencer writes INIT_VALUE to every address of every bank in parallel. It
// writes one address per cycle. While it runs, all bank requests are refused.
//
// Optional feature: define TCDM_BANKS_PARITY_EN to store one even-parity bit
// per byte. Each bit is written together with its byte and checked on reads.
//
// Ports:
//   clk_i, rst_i   - rising-edge clock, asynchronous active-high reset
//   init_req_i     - single-cycle pulse that re-runs the init sequence
//   init_busy_o    - high while the init sequence runs
//   req_i          - per-bank request
//   wen_i          - per-bank 1=read, 0=write
//   be_i           - per-bank byte enables
//   add_i          - per-bank 32-bit word address (low $clog2(BANK_SIZE) used)
//   wdata_i        - per-bank write data
//   gnt_o          - per-bank grant (combinational)
//   r_valid_o      - per-bank read-data valid pulse
//   rdata_o        - per-bank read data, held between pulses
//   r_err_o        - per-bank parity error, qualified by r_valid_o
// ---------------------------------------------------------------------------
module tcdm_banks_pipe_wrap #(
  parameter int unsigned            NB_BANKS     = 16,
  parameter int unsigned            BANK_SIZE    = 1024,
  parameter int unsigned            DATA_WIDTH   = 32,
  parameter int unsigned            READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE   = '0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             init_req_i,
  output logic                             init_busy_o,
  input  logic [NB_BANKS-1:0]              req_i,
  input  logic [NB_BANKS-1:0]              wen_i,
  input  logic [NB_BANKS*DATA_WIDTH/8-1:0] be_i,
  input  logic [NB_BANKS*32-1:0]           add_i,
  input  logic [NB_BANKS*DATA_WIDTH-1:0]   wdata_i,
  output logic [NB_BANKS-1:0]              gnt_o,
  output logic [NB_BANKS-1:0]              r_valid_o,
  output logic [NB_BANKS*DATA_WIDTH-1:0]   rdata_o,
  output logic [NB_BANKS-1:0]              r_err_o
);

  localparam int unsigned ADDR_W = $clog2(BANK_SIZE);
  localparam int unsigned BE_W   = DATA_WIDTH / 8;

  typedef enum logic {
    INIT,
    IDLE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Init sequencer. The counter walks 0..BANK_SIZE-1 while in INIT. The last
  // address is written on the same edge that returns the FSM to IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(BANK_SIZE - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (init_req_i) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign init_busy_o = (state_q == INIT);
  assign gnt_o       = req_i & {NB_BANKS{~init_busy_o}};

  for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
    logic [ADDR_W-1:0]     addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_W-1:0]       be;
    logic                  unused_add_hi;

    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BE_W-1:0]       wr_be;

    logic [DATA_WIDTH-1:0] mem_q [BANK_SIZE];

    logic [READ_LATENCY-1:0]                 vld_q, vld_d;
    logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_q, data_d;

    assign addr          = add_i[b*32 +: ADDR_W];
    assign wdata         = wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
    assign be            = be_i[b*BE_W +: BE_W];
    // Upper address bits are ignored, so addresses wrap modulo BANK_SIZE.
    assign unused_add_hi = ^add_i[b*32+ADDR_W +: 32-ADDR_W];

    assign rd_en = req_i[b] & wen_i[b] & ~init_busy_o;

    // The init sequencer owns the write port while busy. In that state no
    // request is granted, so there is never a conflict.
    always_comb begin
      wr_en   = 1'b0;
      wr_addr = addr;
      wr_data = wdata;
      wr_be   = be;
      if (init_busy_o) begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = INIT_VALUE;
        wr_be   = '1;
      end else if (req_i[b] && !wen_i[b]) begin
        wr_en = 1'b1;
      end
    end

    // Storage is deliberately not reset. Its contents come only from the
    // init sequence and granted writes.
    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wr_be[i]) begin
            mem_q[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
          end
        end
      end
    end

    // Read pipeline. The word is sampled on the grant edge, so a write from
    // the previous cycle is already visible. Each data stage loads only when
    // a valid read enters it. As a result the last stage, which drives
    // rdata_o, holds its value between pulses.
    always_comb begin
      vld_d    = '0;
      data_d   = data_q;
      vld_d[0] = rd_en;
      if (rd_en) begin
        data_d[0] = mem_q[addr];
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        vld_d[k] = vld_q[k-1];
        if (vld_q[k-1]) begin
          data_d[k] = data_q[k-1];
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        vld_q  <= '0;
        data_q <= '0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    assign r_valid_o[b]                          = vld_q[READ_LATENCY-1];
    assign rdata_o[b*DATA_WIDTH +: DATA_WIDTH]   = data_q[READ_LATENCY-1];

`ifdef TCDM_BANKS_PARITY_EN
    logic [BE_W-1:0]         par_q [BANK_SIZE];
    logic [BE_W-1:0]         wr_par;
    logic [BE_W-1:0]         bad_byte;
    logic                    rd_err;
    logic [READ_LATENCY-1:0] err_q, err_d;

    // Even parity: each stored byte plus its parity bit has an even number
    // of ones. A read flags an error only on bytes it enables.
    always_comb begin
      wr_par   = '0;
      bad_byte = '0;
      for (int i = 0; i < BE_W; i++) begin
        wr_par[i]   = ^wr_data[i*8 +: 8];
        bad_byte[i] = ^{mem_q[addr][i*8 +: 8], par_q[addr][i]};
      end
    end

    assign rd_err = |(bad_byte & be);

    always_ff @(posedge clk_i) begin
      if (wr_en) begin
        for (int i = 0; i < BE_W; i++) begin
          if (wr_be[i]) begin
            par_q[wr_addr][i] <= wr_par[i];
          end
        end
      end
    end

    // The error flag travels alongside its data through the pipeline.
    always_comb begin
      err_d    = '0;
      err_d[0] = rd_en & rd_err;
      for (int k = 1; k < READ_LATENCY; k++) begin
        err_d[k] = vld_q[k-1] & err_q[k-1];
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        err_q <= '0;
      end else begin
        err_q <= err_d;
      end
    end

    assign r_err_o[b] = vld_q[READ_LATENCY-1] & err_q[READ_LATENCY-1];
`else
    assign r_err_o[b] = 1'b0;
`endif
  end

endmodule
